// File: rtl/timing_adapter_pkg.sv
// Shared helpers for the parametrised Avalon-ST timing adapter.
// Payload layout, LSB first: error, empty, eop, sop, data.
package timing_adapter_pkg;

  localparam int DROP_CNT_W = 16;
  localparam int ERR_BIT    = 0;
  localparam int EMPTY_LSB  = 1;

  function automatic int payload_w(input int data_w, input int empty_w);
    return data_w + 3 + empty_w;
  endfunction

  function automatic int eop_bit(input int empty_w);
    return EMPTY_LSB + empty_w;
  endfunction

  function automatic int sop_bit(input int empty_w);
    return EMPTY_LSB + empty_w + 1;
  endfunction

  function automatic int data_lsb(input int empty_w);
    return EMPTY_LSB + empty_w + 2;
  endfunction

  // Occupancy spans 0..depth inclusive, so it needs one more code than a pointer.
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/timing_adapter_fifo_param.sv
// Generic show-ahead FIFO: the head entry is visible combinationally on rd_data.
// Occupancy is kept in its own counter so a full FIFO is distinguishable from an empty one.
module timing_adapter_fifo_param
  import timing_adapter_pkg::*;
#(
  parameter int PAYLOAD_W = 12,
  parameter int DEPTH     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [PAYLOAD_W-1:0]       wr_data,
  input  logic                       rd,
  output logic [PAYLOAD_W-1:0]       rd_data,
  output logic [fill_w(DEPTH)-1:0]   fill_level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = fill_w(DEPTH);

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 wr_ok, rd_ok;

  assign full    = (fill_level == FW'(DEPTH));
  assign empty   = (fill_level == '0);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_ok   = wr & (~full | rd);
  assign rd_ok   = rd & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   fill_level <= fill_level + FW'(1);
        2'b01:   fill_level <= fill_level - FW'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/timing_adapter_param.sv
// Avalon-ST timing adapter: absorbs upstream ready latency in a show-ahead FIFO,
// drives a registered in_ready from a fill threshold and drops/counts overflowing beats.
module timing_adapter_param
  import timing_adapter_pkg::*;
#(
  parameter int DATA_W           = 8,
  parameter int EMPTY_W          = 1,
  parameter int DEPTH            = 64,
  parameter int READY_THRESH     = 40,
  parameter int IN_READY_LATENCY = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      in_ready,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_startofpacket,
  input  logic                      in_endofpacket,
  input  logic [EMPTY_W-1:0]        in_empty,
  input  logic                      in_error,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic                      out_error,
  output logic [fill_w(DEPTH)-1:0]  fill_level,
  output logic                      overflow,
  output logic [DROP_CNT_W-1:0]     drop_count
);

  localparam int PW = payload_w(DATA_W, EMPTY_W);
  localparam int FW = fill_w(DEPTH);

  if (READY_THRESH > DEPTH - IN_READY_LATENCY - 1) begin : g_thresh_chk
    $error("READY_THRESH leaves too little headroom for IN_READY_LATENCY");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("DEPTH must be a power of two");
  end

  logic [PW-1:0] in_pl, out_pl;
  logic          fifo_full, fifo_empty;
  logic          rd, drop, wr_acc;
  logic [FW-1:0] fill_next;

  assign in_pl = {in_data, in_startofpacket, in_endofpacket, in_empty, in_error};

  assign out_valid = ~fifo_empty;
  assign rd        = out_valid & out_ready;
  // A beat is lost only when full and nothing leaves this cycle.
  assign drop      = in_valid & fifo_full & ~rd;
  assign wr_acc    = in_valid & ~drop;

  timing_adapter_fifo_param #(
    .PAYLOAD_W (PW),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr_acc),
    .wr_data    (in_pl),
    .rd         (rd),
    .rd_data    (out_pl),
    .fill_level (fill_level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    fill_next = fill_level;
    if (wr_acc && !rd)      fill_next = fill_level + FW'(1);
    else if (!wr_acc && rd) fill_next = fill_level - FW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready   <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      in_ready <= (fill_next < FW'(READY_THRESH));
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
      end
    end
  end

  assign out_error         = out_pl[ERR_BIT];
  assign out_empty         = out_pl[EMPTY_LSB +: EMPTY_W];
  assign out_endofpacket   = out_pl[eop_bit(EMPTY_W)];
  assign out_startofpacket = out_pl[sop_bit(EMPTY_W)];
  assign out_data          = out_pl[data_lsb(EMPTY_W) +: DATA_W];

endmodule

// File: tb/tb_timing_adapter_param.sv
// Directed + random bench for timing_adapter_param against a queue-based reference model.
module tb_timing_adapter_param;

  localparam int DATA_W  = 32;
  localparam int EMPTY_W = 2;
  localparam int DEPTH   = 64;
  localparam int THRESH  = 40;
  localparam int LAT     = 3;
  localparam int PW      = DATA_W + 3 + EMPTY_W;
  localparam int FW      = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_ready, in_valid = 1'b0;
  logic [DATA_W-1:0]  in_data = '0;
  logic               in_startofpacket = 1'b0, in_endofpacket = 1'b0, in_error = 1'b0;
  logic [EMPTY_W-1:0] in_empty = '0;
  logic               out_ready = 1'b0, out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_startofpacket, out_endofpacket, out_error;
  logic [EMPTY_W-1:0] out_empty;
  logic [FW-1:0]      fill_level;
  logic               overflow;
  logic [15:0]        drop_count;

  timing_adapter_param #(
    .DATA_W (DATA_W), .EMPTY_W (EMPTY_W), .DEPTH (DEPTH),
    .READY_THRESH (THRESH), .IN_READY_LATENCY (LAT)
  ) dut (
    .clk (clk), .reset (reset), .in_ready (in_ready), .in_valid (in_valid),
    .in_data (in_data), .in_startofpacket (in_startofpacket),
    .in_endofpacket (in_endofpacket), .in_empty (in_empty), .in_error (in_error),
    .out_ready (out_ready), .out_valid (out_valid), .out_data (out_data),
    .out_startofpacket (out_startofpacket), .out_endofpacket (out_endofpacket),
    .out_empty (out_empty), .out_error (out_error), .fill_level (fill_level),
    .overflow (overflow), .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] out_pl;
  assign out_pl = {out_data, out_startofpacket, out_endofpacket, out_empty, out_error};

  // reference model
  logic [PW-1:0] q[$];
  logic          m_ovf;
  int            m_drops;
  logic          m_rdy;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [DATA_W-1:0] d, input logic sop,
                                       input logic eop, input logic [EMPTY_W-1:0] emp,
                                       input logic err);
    return {d, sop, eop, emp, err};
  endfunction

  function automatic logic [PW-1:0] rnd_pl();
    return mk($urandom, 1'($urandom), 1'($urandom), EMPTY_W'($urandom), 1'($urandom));
  endfunction

  // One clock: drive at negedge, advance model at posedge, check at next negedge.
  task automatic step(input logic r, input logic v, input logic ordy, input logic [PW-1:0] p);
    int  sz;
    logic rd;
    reset = r; in_valid = v; out_ready = ordy;
    {in_data, in_startofpacket, in_endofpacket, in_empty, in_error} = p;
    @(posedge clk);
    if (r) begin
      q.delete(); m_ovf = 1'b0; m_drops = 0; m_rdy = 1'b0;
    end else begin
      sz = q.size();
      rd = (sz != 0) && ordy;
      if (v) begin
        if (sz < DEPTH || rd) q.push_back(p);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (rd) void'(q.pop_front());
      m_rdy = (q.size() < THRESH);
    end
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(m_rdy));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("fill_level", 64'(fill_level), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_drops));
    if (q.size() != 0) chk("payload", 64'(out_pl), 64'(q[0]));
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);

    // 1: short packet with sidebands, sink always ready
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 1'b1, mk(DATA_W'(i), i == 0, i == 9, (i == 9) ? EMPTY_W'(2) : '0, 1'b0));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, '0);
    chk("t1_fill_zero", 64'(fill_level), 64'd0);

    // 2: compliant source against a stalled sink stops at the threshold
    for (int i = 0; i < 50; i++) step(1'b0, in_ready, 1'b0, rnd_pl());
    chk("t2_fill_thresh", 64'(fill_level), 64'(THRESH));
    chk("t2_in_ready_low", 64'(in_ready), 64'd0);

    // 3: source uses its full ready-latency allowance
    for (int i = 0; i < LAT; i++) step(1'b0, 1'b1, 1'b0, rnd_pl());
    chk("t3_fill", 64'(fill_level), 64'(THRESH + LAT));
    chk("t3_no_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < THRESH + LAT + 2; i++) step(1'b0, 1'b0, 1'b1, '0);

    // 4: rogue source overruns a stalled sink by 5 beats
    for (int i = 0; i < DEPTH + 5; i++) step(1'b0, 1'b1, 1'b0, rnd_pl());
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_drops", 64'(drop_count), 64'd5);

    // 5: full FIFO with simultaneous read and write never drops
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, rnd_pl());
    chk("t5_fill_full", 64'(fill_level), 64'(DEPTH));
    chk("t5_drops", 64'(drop_count), 64'd5);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 1'b1, '0);

    // 6: reset while holding a partial packet
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, rnd_pl());
    chk("t6_fill_12", 64'(fill_level), 64'd12);
    step(1'b1, 1'b1, 1'b0, rnd_pl());
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_fill", 64'(fill_level), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);

    // random traffic, including rogue bursts and occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic v, ordy, r;
      r    = ($urandom_range(0, 499) == 0);
      v    = (i % 1000 < 500) ? (in_ready && $urandom_range(0, 3) != 0)
                              : ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 99) < ((i % 700 < 350) ? 30 : 80));
      step(r, v, ordy, rnd_pl());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
